// File: rtl/lock_ctrl_pkg.sv
// lock_ctrl_pkg: shared state encoding, default keys and widths for the lock controller
package lock_ctrl_pkg;
  typedef enum logic [1:0] {
    S_LOCKED,
    S_KEY1_WAIT,
    S_UNLOCKED,
    S_LOCKOUT
  } lock_state_e;
  localparam logic [15:0] KEY0_DEFAULT = 16'hA5C3;
  localparam logic [15:0] KEY1_DEFAULT = 16'h3C5A;
  localparam int FAIL_W = 4;
  localparam int TIMER_W = 8;
endpackage

// File: rtl/lock_timer.sv
// lock_timer: loadable down-counter flagging the final cycle of a window
module lock_timer import lock_ctrl_pkg::*; (
  input  logic               clk,
  input  logic               resetn,
  input  logic               load_i,
  input  logic               clear_i,
  input  logic [TIMER_W-1:0] load_val_i,
  output logic               expired_o
);
  logic [TIMER_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? load_val_i : clear_i ? '0 : (cnt_q != '0) ? cnt_q - TIMER_W'(1) : cnt_q;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign expired_o = (cnt_q == TIMER_W'(1)) && !load_i;
endmodule

// File: rtl/lock_ctrl.sv
// lock_ctrl: two-key unlock window gating single writes to a locked register, with sticky lockout
module lock_ctrl import lock_ctrl_pkg::*; #(
  parameter int                DATA_W   = 16,
  parameter logic [DATA_W-1:0] KEY0     = DATA_W'(KEY0_DEFAULT),
  parameter logic [DATA_W-1:0] KEY1     = DATA_W'(KEY1_DEFAULT),
  parameter int                WINDOW   = 16,
  parameter int                MAX_FAIL = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              key_valid,
  input  logic [DATA_W-1:0] key_data,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  output logic              write_en,
  output logic [DATA_W-1:0] data_out,
  output logic              wr_denied,
  output logic              unlocked,
  output logic              lockout,
  output logic [FAIL_W-1:0] fail_cnt
);
  localparam logic [FAIL_W-1:0] MAX_F = FAIL_W'(MAX_FAIL);
  lock_state_e state_q, state_d;
  logic [FAIL_W-1:0] fail_q, fail_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic we_q, we_d, den_q, den_d, unl_q, lo_q;
  logic fail_inc, tmr_load, tmr_clear, expired;
  // load is derived from inputs and current state only, so expired never loops back through it
  assign tmr_load = key_valid && ((state_q == S_LOCKED && key_data == KEY0) ||
                                  (state_q == S_KEY1_WAIT && key_data == KEY1));
  assign tmr_clear = !tmr_load && (state_d == S_LOCKED || state_d == S_LOCKOUT);
  lock_timer u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .load_i     (tmr_load),
    .clear_i    (tmr_clear),
    .load_val_i (TIMER_W'(WINDOW)),
    .expired_o  (expired)
  );
  always_comb begin
    state_d = state_q;
    fail_d = fail_q;
    dout_d = dout_q;
    we_d = 1'b0;
    fail_inc = 1'b0;
    unique case (state_q)
      S_LOCKED: begin
        if (key_valid) begin
          if (key_data == KEY0) state_d = S_KEY1_WAIT;
          else fail_inc = 1'b1;
        end
      end
      S_KEY1_WAIT: begin
        if (key_valid && key_data == KEY1) begin
          state_d = S_UNLOCKED;
          fail_d = '0;
        end else if (key_valid) begin
          state_d = S_LOCKED;
          fail_inc = 1'b1;
        end else if (expired) state_d = S_LOCKED;
      end
      S_UNLOCKED: begin
        if (wr_req) begin
          we_d = 1'b1;
          dout_d = wr_data;
          state_d = S_LOCKED;
        end else if (expired || key_valid) state_d = S_LOCKED;
      end
      default: ;
    endcase
    if (fail_inc && fail_q != MAX_F) fail_d = fail_q + FAIL_W'(1);
    if (fail_d == MAX_F) state_d = S_LOCKOUT;
    den_d = wr_req && state_q != S_UNLOCKED;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_LOCKED;
      fail_q <= '0;
      dout_q <= '0;
      we_q <= 1'b0;
      den_q <= 1'b0;
      unl_q <= 1'b0;
      lo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fail_q <= fail_d;
      dout_q <= dout_d;
      we_q <= we_d;
      den_q <= den_d;
      unl_q <= state_d == S_UNLOCKED;
      lo_q <= state_d == S_LOCKOUT;
    end
  end
  assign write_en = we_q;
  assign data_out = dout_q;
  assign wr_denied = den_q;
  assign unlocked = unl_q;
  assign lockout = lo_q;
  assign fail_cnt = fail_q;
endmodule

// File: tb/tb_lock_ctrl.sv
// tb_lock_ctrl: directed and random checks of lock_ctrl against a window-counting reference model
module tb_lock_ctrl;
  localparam int DW = 16;
  localparam int WIN = 16;
  localparam int MF = 3;
  localparam logic [DW-1:0] K0 = 16'hA5C3;
  localparam logic [DW-1:0] K1 = 16'h3C5A;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic key_valid = 1'b0;
  logic wr_req = 1'b0;
  logic [DW-1:0] key_data = '0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] data_out;
  logic write_en, wr_denied, unlocked, lockout;
  logic [3:0] fail_cnt;
  int checks = 0;
  int errors = 0;
  int m_unl, m_k1, m_fail;
  bit m_lo, m_we, m_den;
  logic [DW-1:0] m_dout;

  lock_ctrl #(.DATA_W(DW), .KEY0(K0), .KEY1(K1), .WINDOW(WIN), .MAX_FAIL(MF)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .key_valid (key_valid),
    .key_data  (key_data),
    .wr_req    (wr_req),
    .wr_data   (wr_data),
    .write_en  (write_en),
    .data_out  (data_out),
    .wr_denied (wr_denied),
    .unlocked  (unlocked),
    .lockout   (lockout),
    .fail_cnt  (fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_unl = 0; m_k1 = 0; m_fail = 0; m_lo = 0; m_we = 0; m_den = 0; m_dout = '0;
  endtask

  // m_unl / m_k1 hold the cycles left in the unlock / key1 windows, 0 when inactive
  task automatic model(bit kv, logic [DW-1:0] kd, bit wr, logic [DW-1:0] wd);
    m_we = 0;
    m_den = 0;
    if (m_lo) m_den = wr;
    else if (m_unl > 0) begin
      if (wr) begin
        m_we = 1; m_dout = wd; m_unl = 0;
      end else m_unl = kv ? 0 : m_unl - 1;
    end else if (m_k1 > 0) begin
      m_den = wr;
      if (kv) begin
        if (kd == K1) begin m_unl = WIN; m_fail = 0; end
        else m_fail++;
        m_k1 = 0;
      end else m_k1--;
    end else begin
      m_den = wr;
      if (kv) begin
        if (kd == K0) m_k1 = WIN;
        else m_fail++;
      end
    end
    if (m_fail >= MF) begin m_fail = MF; m_lo = 1; end
  endtask

  task automatic check_all();
    chk("write_en", 32'(write_en), 32'(m_we));
    chk("data_out", 32'(data_out), 32'(m_dout));
    chk("wr_denied", 32'(wr_denied), 32'(m_den));
    chk("unlocked", 32'(unlocked), 32'(m_unl > 0));
    chk("lockout", 32'(lockout), 32'(m_lo));
    chk("fail_cnt", 32'(fail_cnt), 32'(m_fail));
  endtask

  task automatic step(bit kv, logic [DW-1:0] kd, bit wr, logic [DW-1:0] wd);
    key_valid = kv; key_data = kd; wr_req = wr; wr_data = wd;
    @(posedge clk);
    model(kv, kd, wr, wd);
    #1;
    key_valid = 0; wr_req = 0;
    check_all();
  endtask

  task automatic do_reset();
    resetn = 0;
    #2;
    model_reset();
    check_all();
    @(negedge clk);
    resetn = 1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, '0);
  endtask

  initial begin
    do_reset();
    // locked write straight after reset
    step(0, '0, 1, 16'hBEEF);
    chk("locked_den", 32'(wr_denied), 32'd1);
    chk("locked_dout", 32'(data_out), 32'd0);
    // unlock and write
    step(1, K0, 0, '0);
    step(1, K1, 0, '0);
    chk("unl_up", 32'(unlocked), 32'd1);
    step(0, '0, 1, 16'h1234);
    chk("wr_we", 32'(write_en), 32'd1);
    chk("wr_dout", 32'(data_out), 32'h1234);
    chk("wr_unl", 32'(unlocked), 32'd0);
    step(0, '0, 0, '0);
    chk("we_one_cycle", 32'(write_en), 32'd0);
    chk("dout_hold", 32'(data_out), 32'h1234);
    // second write without fresh keys is denied
    step(0, '0, 1, 16'h5555);
    chk("b2b_den", 32'(wr_denied), 32'd1);
    // write on the last window cycle
    step(1, K0, 0, '0);
    step(1, K1, 0, '0);
    idle(WIN - 1);
    chk("win_last_unl", 32'(unlocked), 32'd1);
    step(0, '0, 1, 16'hA001);
    chk("win_last_we", 32'(write_en), 32'd1);
    // write one cycle after expiry
    step(1, K0, 0, '0);
    step(1, K1, 0, '0);
    idle(WIN);
    chk("win_exp_unl", 32'(unlocked), 32'd0);
    step(0, '0, 1, 16'hA002);
    chk("win_exp_den", 32'(wr_denied), 32'd1);
    chk("win_exp_we", 32'(write_en), 32'd0);
    // key1 wait expiry is not a failure
    step(1, K0, 0, '0);
    idle(WIN + 1);
    chk("k1_exp_fail", 32'(fail_cnt), 32'd0);
    // simultaneous write and bad key while unlocked
    step(1, K0, 0, '0);
    step(1, K1, 0, '0);
    step(1, 16'h0000, 1, 16'h00FF);
    chk("sim_we", 32'(write_en), 32'd1);
    chk("sim_dout", 32'(data_out), 32'h00FF);
    chk("sim_fail", 32'(fail_cnt), 32'd0);
    // reset on the write_en cycle drops the strobe immediately
    step(1, K0, 0, '0);
    step(1, K1, 0, '0);
    step(0, '0, 1, 16'h7777);
    chk("pre_rst_we", 32'(write_en), 32'd1);
    resetn = 0;
    #1;
    chk("rst_we", 32'(write_en), 32'd0);
    model_reset();
    check_all();
    @(negedge clk);
    resetn = 1;
    // lockout after three bad keys
    step(1, 16'h0000, 0, '0);
    step(1, 16'h0000, 0, '0);
    chk("pre_lo", 32'(lockout), 32'd0);
    step(1, 16'h0000, 0, '0);
    chk("lo_fail", 32'(fail_cnt), 32'd3);
    chk("lo_flag", 32'(lockout), 32'd1);
    step(1, K0, 0, '0);
    step(1, K1, 0, '0);
    step(0, '0, 1, 16'h4321);
    chk("lo_den", 32'(wr_denied), 32'd1);
    chk("lo_we", 32'(write_en), 32'd0);
    // reset clears lockout and the next unlock works
    do_reset();
    chk("rst_lo", 32'(lockout), 32'd0);
    step(1, K0, 0, '0);
    step(1, K1, 0, '0);
    step(0, '0, 1, 16'h9999);
    chk("post_rst_we", 32'(write_en), 32'd1);
    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [DW-1:0] kd;
      int sel;
      bit kv, wr;
      if ($urandom_range(0, 99) < 2) do_reset();
      sel = $urandom_range(0, 3);
      kd = (sel == 0) ? K0 : (sel == 1) ? K1 : (sel == 2) ? 16'h0000 : DW'($urandom);
      kv = $urandom_range(0, 99) < 35;
      wr = $urandom_range(0, 99) < 20;
      step(kv, kd, wr, DW'($urandom));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
